// File: rtl/ctrl_mc_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, major
// opcodes, memory/compare subfields, ALU op codes and the halt encoding.
package ctrl_mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // Major opcode, instruction bits [8:7]
  localparam logic [1:0] MEMCMP = 2'b00;
  localparam logic [1:0] ONEVAR = 2'b01;
  localparam logic [1:0] TWOVAR = 2'b10;
  localparam logic [1:0] BRANCH = 2'b11;

  // MEMCMP subfield, instruction bits [6:4]
  localparam logic [2:0] SUB_GET = 3'b000;
  localparam logic [2:0] SUB_PUT = 3'b001;
  localparam logic [2:0] SUB_LW  = 3'b010;
  localparam logic [2:0] SUB_SW  = 3'b011;
  localparam logic [2:0] SUB_SEQ = 3'b100;
  localparam logic [2:0] SUB_SNE = 3'b101;
  localparam logic [2:0] SUB_SLT = 3'b110;

  // ALU op codes for the compare instructions
  localparam logic [3:0] ALU_SEQ = 4'b1000;
  localparam logic [3:0] ALU_SNE = 4'b1001;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  localparam logic [8:0] HALT_INST = 9'h1FF;

endpackage

// File: rtl/ctrl_mc_if.sv
// Bus between the control unit and its instruction ROM, ALU and data memory.
//
// Memory handshake: MemReq is the valid, MemAck the ready. Once MemReq rises
// it stays high, and MemAddr/MemWData/MemWe stay stable, until the cycle in
// which MemAck is sampled high; that edge completes the transfer (and
// captures MemRData for a load). MemAck while MemReq is low has no effect.
interface ctrl_mc_if #(
  parameter int W   = 8,
  parameter int PCW = 10
);
  logic [PCW-1:0] InstAddr;
  logic [8:0]     Instruction;
  logic [W-1:0]   AluA;
  logic [W-1:0]   AluB;
  logic [3:0]     AluOp;
  logic [W-1:0]   AluResult;
  logic           MemReq;
  logic           MemWe;
  logic [W-1:0]   MemAddr;
  logic [W-1:0]   MemWData;
  logic           MemAck;
  logic [W-1:0]   MemRData;

  modport master (
    output InstAddr, AluA, AluB, AluOp, MemReq, MemWe, MemAddr, MemWData,
    input  Instruction, AluResult, MemAck, MemRData
  );

  modport slave (
    input  InstAddr, AluA, AluB, AluOp, MemReq, MemWe, MemAddr, MemWData,
    output Instruction, AluResult, MemAck, MemRData
  );
endinterface

// File: rtl/ctrl_regfile.sv
// Four-entry architectural register file: three combinational read ports
// (a branch compares two registers and takes its offset from a third) and
// one synchronous write port, cleared synchronously on Reset.
module ctrl_regfile #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [1:0]   ra_a,
  input  logic [1:0]   ra_b,
  input  logic [1:0]   ra_c,
  output logic [W-1:0] rd_a,
  output logic [W-1:0] rd_b,
  output logic [W-1:0] rd_c,
  input  logic         we,
  input  logic [1:0]   wa,
  input  logic [W-1:0] wd
);
  logic [W-1:0] regs [4];

  // Clear on reset, otherwise single write per cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a = regs[ra_a];
  assign rd_b = regs[ra_b];
  assign rd_c = regs[ra_c];
endmodule

// File: rtl/ctrl_mc.sv
// Multicycle control unit for the 9-bit ISA: owns PC, register file and the
// fetch/execute/memory FSM; drives the external ALU and the data memory.
module ctrl_mc
  import ctrl_mc_pkg::*;
#(
  parameter int W   = 8,
  parameter int PCW = 10
) (
  input  logic      Clk,
  input  logic      Reset,
  input  logic      Start,
  ctrl_mc_if.master bus,
  output logic      Done,
  output state_t    State
);
  state_t         state;
  logic [PCW-1:0] pc;
  logic           done_r;
  logic           mem_we_r;
  logic [W-1:0]   mem_addr_r;
  logic [W-1:0]   mem_wdata_r;
  logic [1:0]     mem_rd;

  logic [8:0]     inst;
  logic [1:0]     rc_addr;
  logic [W-1:0]   ra;
  logic [W-1:0]   rb;
  logic [W-1:0]   rc;

  // Decode results for the instruction currently presented by the ROM
  logic           ex_we;
  logic [1:0]     ex_wa;
  logic [W-1:0]   ex_wd;
  logic [3:0]     alu_op;
  logic           is_mem;
  logic           is_store;
  logic           is_halt;
  logic [PCW-1:0] pc_next;
  logic [PCW-1:0] offset;

  logic           rf_we;
  logic [1:0]     rf_wa;
  logic [W-1:0]   rf_wd;

  assign inst = bus.Instruction;

  // Third read port serves R3 for put, and R[I[5:4]] for not/branch
  assign rc_addr = (inst[8:7] == MEMCMP) ? 2'd3 : inst[5:4];

  ctrl_regfile #(.W(W)) u_rf (
    .Clk   (Clk),
    .Reset (Reset),
    .ra_a  (inst[3:2]),
    .ra_b  (inst[1:0]),
    .ra_c  (rc_addr),
    .rd_a  (ra),
    .rd_b  (rb),
    .rd_c  (rc),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

  // Instruction decode and next-PC computation used during EXEC
  always_comb begin
    ex_we    = 1'b0;
    ex_wa    = inst[3:2];
    ex_wd    = bus.AluResult;
    alu_op   = 4'b0000;
    is_mem   = 1'b0;
    is_store = 1'b0;
    is_halt  = 1'b0;
    offset   = PCW'(rb);
    pc_next  = pc + PCW'(1);
    if (inst == HALT_INST) begin
      is_halt = 1'b1;
    end else begin
      case (inst[8:7])
        MEMCMP: begin
          case (inst[6:4])
            SUB_GET: begin ex_we = 1'b1; ex_wa = 2'd3;      ex_wd = rb; end
            SUB_PUT: begin ex_we = 1'b1; ex_wa = inst[1:0]; ex_wd = rc; end
            SUB_LW:  is_mem = 1'b1;
            SUB_SW:  begin is_mem = 1'b1; is_store = 1'b1; end
            SUB_SEQ: begin ex_we = 1'b1; alu_op = ALU_SEQ; end
            SUB_SNE: begin ex_we = 1'b1; alu_op = ALU_SNE; end
            SUB_SLT: begin ex_we = 1'b1; alu_op = ALU_SLT; end
            default: ;
          endcase
        end
        ONEVAR: begin
          ex_we = 1'b1;
          if (inst[6]) begin
            ex_wa = 2'd3;
            ex_wd = W'(inst[5:0]);
          end else begin
            ex_wa = inst[5:4];
            ex_wd = ~rc;
          end
        end
        TWOVAR: begin
          ex_we  = 1'b1;
          alu_op = {1'b0, inst[6:4]};
        end
        default: begin
          // BRANCH: an offset of zero on a taken branch re-executes it
          if (rc == ra) pc_next = inst[6] ? (pc - offset) : (pc + offset);
        end
      endcase
    end
  end

  // Register write: EXEC results, or load data on the completing MEM edge
  always_comb begin
    rf_we = 1'b0;
    rf_wa = ex_wa;
    rf_wd = ex_wd;
    if (state == S_EXEC) begin
      rf_we = ex_we;
    end else if (state == S_MEM) begin
      rf_we = bus.MemAck && !mem_we_r;
      rf_wa = mem_rd;
      rf_wd = bus.MemRData;
    end
  end

  // Control FSM with PC, Done and memory request registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      done_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_rd      <= 2'd0;
    end else begin
      case (state)
        S_IDLE:  if (Start) state <= S_FETCH;
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          if (is_halt) begin
            state  <= S_HALT;
            done_r <= 1'b1;
          end else if (is_mem) begin
            state       <= S_MEM;
            mem_we_r    <= is_store;
            mem_addr_r  <= rb;
            mem_wdata_r <= ra;
            mem_rd      <= inst[3:2];
          end else begin
            state <= S_FETCH;
            pc    <= pc_next;
          end
        end
        S_MEM: begin
          if (bus.MemAck) begin
            state <= S_FETCH;
            pc    <= pc + PCW'(1);
          end
        end
        S_HALT: begin
          if (Start) begin
            state  <= S_FETCH;
            done_r <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.InstAddr = pc;
  assign bus.AluA     = ra;
  assign bus.AluB     = rb;
  assign bus.AluOp    = (state == S_EXEC) ? alu_op : 4'b0000;
  assign bus.MemReq   = (state == S_MEM);
  assign bus.MemWe    = mem_we_r;
  assign bus.MemAddr  = mem_addr_r;
  assign bus.MemWData = mem_wdata_r;
  assign Done         = done_r;
  assign State        = state;
endmodule

// File: tb/tb_ctrl_mc.sv
// Directed bench for ctrl_mc: synchronous ROM and adding ALU models, memory
// acknowledge driven by hand, hand-computed expectations.
module tb_ctrl_mc;
  import ctrl_mc_pkg::*;

  localparam int W   = 8;
  localparam int PCW = 10;
  localparam logic [8:0] NOP = 9'b001110000;

  logic   Clk = 1'b0;
  logic   Reset = 1'b1;
  logic   Start = 1'b0;
  logic   Done;
  state_t state_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] rom [1 << PCW];

  ctrl_mc_if #(.W(W), .PCW(PCW)) bus ();

  ctrl_mc #(.W(W), .PCW(PCW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .bus   (bus),
    .Done  (Done),
    .State (state_o)
  );

  // clock
  always #5 Clk = ~Clk;

  // synchronous instruction ROM
  always @(posedge Clk) bus.Instruction <= rom[bus.InstAddr];

  // ALU model: add for op 0000, zero otherwise
  always_comb begin
    bus.AluResult = '0;
    if (bus.AluOp == 4'b0000) bus.AluResult = bus.AluA + bus.AluB;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < (1 << PCW); i++) rom[i] = NOP;
  endtask

  // R0=5, R1=5 or 0, R2=3, nops up to PC 10 where the branch sits
  task automatic run_branch(input string tag, input logic [8:0] br,
                            input logic set_r1, input logic [31:0] exp_pc);
    clear_rom();
    rom[0] = 9'b011000011;
    rom[1] = 9'b000010010;
    rom[2] = 9'b011000101;
    rom[3] = 9'b000010000;
    rom[4] = set_r1 ? 9'b000010001 : NOP;
    rom[10] = br;
    do_reset();
    pulse_start();
    repeat (20) tick();
    check({tag, "_at10"}, bus.InstAddr, 32'd10);
    repeat (2) tick();
    check(tag, bus.InstAddr, exp_pc);
  endtask

  // PC 3 branches backward by 4 to 1023, where the instruction under test sits
  task automatic run_wrap(input string tag, input logic [8:0] br, input logic [31:0] exp_pc);
    clear_rom();
    rom[0] = 9'b011000100;
    rom[1] = 9'b000010010;
    rom[2] = 9'b011000001;
    rom[3] = 9'b111000110;
    rom[1023] = br;
    do_reset();
    pulse_start();
    repeat (8) tick();
    check({tag, "_at_top"}, bus.InstAddr, 32'd1023);
    repeat (2) tick();
    check(tag, bus.InstAddr, exp_pc);
  endtask

  initial begin
    bus.MemAck   = 1'b0;
    bus.MemRData = '0;
    clear_rom();

    // reset values
    tick();
    tick();
    Reset = 1'b0;
    check("rst_state", state_o, S_IDLE);
    check("rst_pc", bus.InstAddr, 32'd0);
    check("rst_done", Done, 1'b0);
    check("rst_memreq", bus.MemReq, 1'b0);
    check("rst_memwe", bus.MemWe, 1'b0);
    check("rst_memaddr", bus.MemAddr, 32'd0);
    check("rst_memwdata", bus.MemWData, 32'd0);
    check("rst_aluop", bus.AluOp, 32'd0);

    // R3<-5, put R0, halt
    rom[0] = 9'b011000101;
    rom[1] = 9'b000010000;
    rom[2] = 9'h1FF;
    pulse_start();
    check("t1_fetch", state_o, S_FETCH);
    repeat (5) tick();
    check("t1_done_early", Done, 1'b0);
    tick();
    check("t1_done", Done, 1'b1);
    check("t1_state_halt", state_o, S_HALT);
    check("t1_pc", bus.InstAddr, 32'd2);
    check("t1_r3", dut.u_rf.regs[3], 32'd5);
    check("t1_r0", dut.u_rf.regs[0], 32'd5);
    repeat (3) tick();
    check("t1_pc_hold", bus.InstAddr, 32'd2);
    pulse_start();
    check("t1_done_clr", Done, 1'b0);
    check("t1_restart", state_o, S_FETCH);
    repeat (2) tick();
    check("t1_rehalt", Done, 1'b1);

    // R0=3, R1=4, add R0,R1
    clear_rom();
    rom[0] = 9'b011000011;
    rom[1] = 9'b000010000;
    rom[2] = 9'b011000100;
    rom[3] = 9'b000010001;
    rom[4] = 9'b100000001;
    do_reset();
    pulse_start();
    repeat (8) tick();
    tick();
    check("t2_exec", state_o, S_EXEC);
    check("t2_aluop", bus.AluOp, 32'd0);
    check("t2_alua", bus.AluA, 32'd3);
    check("t2_alub", bus.AluB, 32'd4);
    tick();
    check("t2_r0", dut.u_rf.regs[0], 32'd7);
    check("t2_pc", bus.InstAddr, 32'd5);
    check("t2_fetch", state_o, S_FETCH);

    // lw R0<-Mem[R1], R1=8, ack in the fourth MEM cycle
    clear_rom();
    rom[0] = 9'b011001000;
    rom[1] = 9'b000010001;
    rom[2] = 9'b000100001;
    do_reset();
    pulse_start();
    repeat (4) tick();
    tick();
    check("t3_exec_noreq", bus.MemReq, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t3_memreq", bus.MemReq, 1'b1);
      check("t3_memaddr", bus.MemAddr, 32'd8);
      check("t3_memwe", bus.MemWe, 1'b0);
      check("t3_r0_wait", dut.u_rf.regs[0], 32'd0);
      if (i == 3) begin
        bus.MemAck   = 1'b1;
        bus.MemRData = 8'hA5;
      end
      tick();
    end
    bus.MemAck = 1'b0;
    check("t3_r0", dut.u_rf.regs[0], 32'hA5);
    check("t3_reqdrop", bus.MemReq, 1'b0);
    check("t3_pc", bus.InstAddr, 32'd3);
    check("t3_fetch", state_o, S_FETCH);

    // branches at PC 10
    run_branch("t4_fwd", 9'b110000110, 1'b1, 32'd13);
    run_branch("t4_back", 9'b111000110, 1'b1, 32'd7);
    run_branch("t4_ne", 9'b110000110, 1'b0, 32'd11);

    // PC wrap at the top of the address space
    run_wrap("t5_back", 9'b111000111, 32'd1022);
    run_wrap("t5_fwd", 9'b110000111, 32'd0);

    // sw Mem[R1=9]<-R0=42, reset in the first MEM cycle
    clear_rom();
    rom[0] = 9'b011001001;
    rom[1] = 9'b000010001;
    rom[2] = 9'b011101010;
    rom[3] = 9'b000010000;
    rom[4] = 9'b000110001;
    do_reset();
    pulse_start();
    repeat (8) tick();
    tick();
    tick();
    check("t6_memreq", bus.MemReq, 1'b1);
    check("t6_memwe", bus.MemWe, 1'b1);
    check("t6_memaddr", bus.MemAddr, 32'd9);
    check("t6_memwdata", bus.MemWData, 32'd42);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("t6_rst_memreq", bus.MemReq, 1'b0);
    check("t6_rst_state", state_o, S_IDLE);
    for (int i = 0; i < 4; i++) check("t6_rst_reg", dut.u_rf.regs[i], 32'd0);
    check("t6_rst_pc", bus.InstAddr, 32'd0);
    check("t6_rst_memwe", bus.MemWe, 1'b0);
    repeat (3) tick();
    check("t6_no_retry", bus.MemReq, 1'b0);
    pulse_start();
    check("t6_restart", state_o, S_FETCH);
    check("t6_restart_pc", bus.InstAddr, 32'd0);
    repeat (2) tick();
    check("t6_r3_after", dut.u_rf.regs[3], 32'd9);
    check("t6_pc1", bus.InstAddr, 32'd1);

    // same store again, acknowledged in its first MEM cycle
    repeat (6) tick();
    tick();
    tick();
    check("t7_mem", state_o, S_MEM);
    bus.MemAck = 1'b1;
    tick();
    check("t7_fast_ack", state_o, S_FETCH);
    check("t7_pc", bus.InstAddr, 32'd5);
    // ack held high through a nop is ignored
    repeat (2) tick();
    check("t7_ack_ignored", state_o, S_FETCH);
    check("t7_pc_nop", bus.InstAddr, 32'd6);
    bus.MemAck = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
